// File: rtl/vtracer_pkg.sv
// Shared vtracer datapath constants, FSM state encoding and vector component index.
package vtracer_pkg;
  localparam int VEC_W     = 20;
  localparam int MOLD_W    = 16;
  localparam int NORM_FRAC = 14;
  localparam int NORM_ONE  = 16384;

  typedef enum logic [1:0] {IDLE, DIV, DONE} norm_state_e;
  typedef enum logic [1:0] {X, Y, Z} comp_e;
endpackage

// File: rtl/vec_normalize_if.sv
// Producer/consumer handshake bundle for vec_normalize.
interface vec_normalize_if #(
  parameter int VEC_W  = vtracer_pkg::VEC_W,
  parameter int MOLD_W = vtracer_pkg::MOLD_W,
  parameter int OUT_W  = vtracer_pkg::NORM_FRAC + 2
);
  logic              in_valid;
  logic              in_ready;
  logic [VEC_W-1:0]  x;
  logic [VEC_W-1:0]  y;
  logic [VEC_W-1:0]  z;
  logic [MOLD_W-1:0] mold;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  nx;
  logic [OUT_W-1:0]  ny;
  logic [OUT_W-1:0]  nz;
  logic              sat;
  logic              div0;

  modport master (
    output in_valid, x, y, z, mold, out_ready,
    input  in_ready, out_valid, nx, ny, nz, sat, div0
  );

  modport slave (
    input  in_valid, x, y, z, mold, out_ready,
    output in_ready, out_valid, nx, ny, nz, sat, div0
  );
endinterface

// File: rtl/udiv_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module udiv_step #(
  parameter int W = 16
) (
  input  logic [W:0]   rem_i,
  input  logic [W-1:0] div_i,
  input  logic         bit_i,
  output logic [W:0]   rem_o,
  output logic         q_o
);
  logic [W+1:0] trial;

  always_comb begin
    trial = {rem_i, bit_i};
    q_o   = (trial >= {2'b00, div_i});
    rem_o = q_o ? (W+1)'(trial - {2'b00, div_i}) : (W+1)'(trial);
  end
endmodule

// File: rtl/vec_normalize.sv
// Divides (x, y, z) by their magnitude with one shared restoring divider,
// producing signed Q1.FRAC components rounded toward zero.
module vec_normalize #(
  parameter int VEC_W  = vtracer_pkg::VEC_W,
  parameter int MOLD_W = vtracer_pkg::MOLD_W,
  parameter int FRAC   = vtracer_pkg::NORM_FRAC
) (
  input logic            clk,
  input logic            rst_n,
  vec_normalize_if.slave io
);
  import vtracer_pkg::*;

  localparam int ABS_W = VEC_W + 1;
  localparam int REM_W = MOLD_W + 1;
  localparam int OUT_W = FRAC + 2;
  localparam int QW    = FRAC + 1;
  localparam int IT_W  = $clog2(FRAC + 1);

  norm_state_e       state_q, state_d;
  comp_e             comp_q, comp_d;
  logic [IT_W-1:0]   iter_q, iter_d;
  logic [REM_W-1:0]  rem_q, rem_d, rem_nxt;
  logic [FRAC-1:0]   quo_q, quo_d;
  logic              q_bit;
  logic [ABS_W-1:0]  abs_q [3];
  logic [ABS_W-1:0]  abs_d [3];
  logic [2:0]        neg_q, neg_d, clamp_q, clamp_d;
  logic [MOLD_W-1:0] mold_q, mold_d;
  logic [OUT_W-1:0]  res_q [2];
  logic [OUT_W-1:0]  res_d [2];
  logic              in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  nx_q, nx_d, ny_q, ny_d, nz_q, nz_d;
  logic              sat_q, sat_d, div0_q, div0_d;

  logic [VEC_W-1:0]  in_c   [3];
  logic [ABS_W-1:0]  in_abs [3];
  logic [ABS_W-1:0]  cur_abs, next_abs;
  logic              cur_neg, cur_clamp, dbit;
  logic [OUT_W-1:0]  res_cur;

  function automatic logic [OUT_W-1:0] apply_sign(logic neg, logic clamp, logic [QW-1:0] q);
    logic [OUT_W-1:0] mag;
    mag = clamp ? (OUT_W'(1) << FRAC) : {1'b0, q};
    return neg ? -mag : mag;
  endfunction

  assign in_c[0] = io.x;
  assign in_c[1] = io.y;
  assign in_c[2] = io.z;

  // One extra bit so that |-2^(VEC_W-1)| is representable.
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      in_abs[i] = in_c[i][VEC_W-1] ? -{in_c[i][VEC_W-1], in_c[i]} : {1'b0, in_c[i]};
    end
  end

  always_comb begin
    unique case (comp_q)
      X:       begin cur_abs = abs_q[0]; cur_neg = neg_q[0]; cur_clamp = clamp_q[0]; next_abs = abs_q[1]; end
      Y:       begin cur_abs = abs_q[1]; cur_neg = neg_q[1]; cur_clamp = clamp_q[1]; next_abs = abs_q[2]; end
      default: begin cur_abs = abs_q[2]; cur_neg = neg_q[2]; cur_clamp = clamp_q[2]; next_abs = abs_q[0]; end
    endcase
  end

  // Quotient has FRAC+1 bits: remainder is preloaded with |c|>>1 and only the
  // low FRAC+1 bits of |c|<<FRAC are shifted in (|c| bit 0, then zeros).
  assign dbit = (iter_q == IT_W'(FRAC)) ? cur_abs[0] : 1'b0;

  udiv_step #(.W(MOLD_W)) u_step (
    .rem_i (rem_q),
    .div_i (mold_q),
    .bit_i (dbit),
    .rem_o (rem_nxt),
    .q_o   (q_bit)
  );

  always_comb begin
    state_d = state_q;
    comp_d  = comp_q;
    iter_d  = iter_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    abs_d   = abs_q;
    neg_d   = neg_q;
    clamp_d = clamp_q;
    mold_d  = mold_q;
    res_d   = res_q;
    nx_d    = nx_q;
    ny_d    = ny_q;
    nz_d    = nz_q;
    sat_d   = sat_q;
    div0_d  = div0_q;
    res_cur = '0;

    unique case (state_q)
      IDLE: begin
        if (io.in_valid && in_ready_q) begin
          for (int unsigned i = 0; i < 3; i++) begin
            abs_d[i]   = in_abs[i];
            neg_d[i]   = in_c[i][VEC_W-1];
            clamp_d[i] = in_abs[i] > ABS_W'(io.mold);
          end
          mold_d = io.mold;
          comp_d = X;
          iter_d = IT_W'(FRAC);
          rem_d  = REM_W'(in_abs[0] >> 1);
          quo_d  = '0;
          if (io.mold == '0) begin
            state_d = DONE;
            nx_d    = '0;
            ny_d    = '0;
            nz_d    = '0;
            sat_d   = 1'b0;
            div0_d  = 1'b1;
          end else begin
            state_d = DIV;
          end
        end
      end
      DIV: begin
        rem_d  = rem_nxt;
        quo_d  = {quo_q[FRAC-2:0], q_bit};
        iter_d = iter_q - IT_W'(1);
        if (iter_q == '0) begin
          res_cur = apply_sign(cur_neg, cur_clamp, {quo_q, q_bit});
          iter_d  = IT_W'(FRAC);
          quo_d   = '0;
          rem_d   = REM_W'(next_abs >> 1);
          unique case (comp_q)
            X: begin res_d[0] = res_cur; comp_d = Y; end
            Y: begin res_d[1] = res_cur; comp_d = Z; end
            default: begin
              state_d = DONE;
              nx_d    = res_q[0];
              ny_d    = res_q[1];
              nz_d    = res_cur;
              sat_d   = |clamp_q;
              div0_d  = 1'b0;
            end
          endcase
        end
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      comp_q      <= X;
      iter_q      <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      abs_q       <= '{default: '0};
      neg_q       <= '0;
      clamp_q     <= '0;
      mold_q      <= '0;
      res_q       <= '{default: '0};
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      nx_q        <= '0;
      ny_q        <= '0;
      nz_q        <= '0;
      sat_q       <= 1'b0;
      div0_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      comp_q      <= comp_d;
      iter_q      <= iter_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      abs_q       <= abs_d;
      neg_q       <= neg_d;
      clamp_q     <= clamp_d;
      mold_q      <= mold_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      nx_q        <= nx_d;
      ny_q        <= ny_d;
      nz_q        <= nz_d;
      sat_q       <= sat_d;
      div0_q      <= div0_d;
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.nx        = nx_q;
  assign io.ny        = ny_q;
  assign io.nz        = nz_q;
  assign io.sat       = sat_q;
  assign io.div0      = div0_q;
endmodule

// File: tb/tb_vec_normalize.sv
// Scoreboard bench for vec_normalize: directed vectors with hand-computed results.
module tb_vec_normalize;
  import vtracer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vec_normalize_if bus ();

  vec_normalize #(.VEC_W(VEC_W), .MOLD_W(MOLD_W), .FRAC(NORM_FRAC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  typedef struct {
    int nx;
    int ny;
    int nz;
    bit sat;
    bit div0;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic exp_t mk(int a, int b, int c, bit s, bit d);
    exp_t e;
    e.nx = a; e.ny = b; e.nz = c; e.sat = s; e.div0 = d;
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: a result is consumed on the next rising edge when valid && ready.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got nx=%0d with empty scoreboard, expected none", $signed(bus.nx));
      end else begin
        e = sb.pop_front();
        chk("nx",   $signed(bus.nx), e.nx);
        chk("ny",   $signed(bus.ny), e.ny);
        chk("nz",   $signed(bus.nz), e.nz);
        chk("sat",  int'(bus.sat),  int'(e.sat));
        chk("div0", int'(bus.div0), int'(e.div0));
      end
    end
  end

  // Called at #1 after a rising edge. lat < 0 skips the latency measurement;
  // otherwise lat is the number of rising edges after the accept edge at which
  // out_valid is first seen high.
  task automatic send(input int xx, input int yy, input int zz, input int mm,
                      input exp_t e, input int lat, input bit scramble);
    int cyc;
    bit seen;
    cyc = 0;
    while (!bus.in_ready && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_timeout: got in_ready=0 after %0d cycles, expected 1", cyc);
      return;
    end
    bus.x = VEC_W'(xx);
    bus.y = VEC_W'(yy);
    bus.z = VEC_W'(zz);
    bus.mold = MOLD_W'(mm);
    bus.in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(e);
    #1 bus.in_valid = 1'b0;
    if (lat < 0) return;
    cyc = 0;
    seen = bus.out_valid;
    while (!seen && cyc < 200) begin
      if (scramble && cyc < 40) begin
        bus.in_valid = 1'b1;
        bus.x = VEC_W'($urandom);
        bus.y = VEC_W'($urandom);
        bus.z = VEC_W'($urandom);
        bus.mold = MOLD_W'($urandom);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      seen = bus.out_valid;
    end
    bus.in_valid = 1'b0;
    chk("latency_edges", cyc, lat);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
    bus.z         = '0;
    bus.mold      = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  int'(bus.in_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_nx",        int'(bus.nx), 0);
    chk("rst_sat",       int'(bus.sat), 0);
    chk("rst_div0",      int'(bus.div0), 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", int'(bus.in_ready), 1);

    send(3, 4, 0, 5,             mk(9830, 13107, 0, 1'b0, 1'b0), 45, 1'b0);
    send(-3, 0, -4, 5,           mk(-9830, 0, -13107, 1'b0, 1'b0), 45, 1'b0);
    send(-524288, 0, 0, 65535,   mk(-16384, 0, 0, 1'b1, 1'b0), 45, 1'b0);
    send(100, -7, 9, 0,          mk(0, 0, 0, 1'b0, 1'b1), 0, 1'b0);
    send(7, 5, 0, 5,             mk(16384, 16384, 0, 1'b1, 1'b0), 45, 1'b0);
    send(65535, -65535, 32768, 65535, mk(16384, -16384, 8192, 1'b0, 1'b0), 45, 1'b0);

    // Backpressure with inputs scrambled during DIV.
    repeat (2) @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send(1, 2, 2, 3, mk(5461, 10922, 10922, 1'b0, 1'b0), 45, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", int'(bus.out_valid), 1);
      chk("bp_in_ready",  int'(bus.in_ready), 0);
      chk("bp_nx",        $signed(bus.nx), 5461);
      chk("bp_nz",        $signed(bus.nz), 10922);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of DIV drops the vector and clears outputs at once.
    send(3, 4, 0, 5, mk(9830, 13107, 0, 1'b0, 1'b0), -1, 1'b0);
    repeat (19) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_in_ready",  int'(bus.in_ready), 0);
    chk("midrst_nx",        int'(bus.nx), 0);
    chk("midrst_ny",        int'(bus.ny), 0);
    chk("midrst_nz",        int'(bus.nz), 0);
    sb.delete();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready_release", int'(bus.in_ready), 1);
    send(6, 8, 0, 10, mk(9830, 13107, 0, 1'b0, 1'b0), 45, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
